// File: rtl/core_pkg.sv
// Shared types for the core pipeline control: EXEC path decisions and the
// stage sequencer state encoding.
package core_pkg;

    typedef enum logic [1:0] {
        CTRL_EXEC = 2'd0,
        CTRL_MEM  = 2'd1,
        CTRL_AMO  = 2'd2
    } ctrl_path_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WFI   = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/core_stage_ctrl.sv
// Multi-cycle instruction sequencer: walks each instruction through FETCH,
// EXEC and MEM, runs the two EXEC passes of an AMO, and handles traps and WFI.
module core_stage_ctrl
    import core_pkg::*;
#(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    fetch_stage_valid,
    input  logic                    fetch_stage_ready,
    output logic                    exec_stage_valid,
    input  logic                    exec_stage_ready,
    output logic                    exec_phase,
    input  ctrl_path_e              ctrl_path,
    output logic                    mem_stage_valid,
    input  logic                    mem_stage_ready,
    input  logic                    wfi,
    input  logic                    irq_pending,
    input  logic                    trap_valid,
    output logic                    wb_valid,
    output logic                    instr_retire,
    output logic                    trap_taken,
    output logic [RETIRE_CNT_W-1:0] retire_count
);

    ctrl_state_e              state_q, state_d;
    ctrl_path_e               path_q, path_d;
    logic                     phase_q, phase_d;
    logic [RETIRE_CNT_W-1:0]  retire_count_q;
    logic                     fetch_done, exec_done, mem_done;

    assign fetch_stage_valid = (state_q == S_FETCH);
    assign exec_stage_valid  = (state_q == S_EXEC);
    assign mem_stage_valid   = (state_q == S_MEM);
    assign exec_phase        = phase_q;
    assign retire_count      = retire_count_q;

    assign fetch_done = fetch_stage_valid && fetch_stage_ready;
    assign exec_done  = exec_stage_valid && exec_stage_ready;
    assign mem_done   = mem_stage_valid && mem_stage_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            path_q         <= CTRL_EXEC;
            phase_q        <= 1'b0;
            retire_count_q <= '0;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            phase_q <= phase_d;
            if (instr_retire) begin
                retire_count_q <= retire_count_q + 1'b1;
            end
        end
    end

    // Pulses are only ever raised on a stage done, so trap_taken excludes wb/retire.
    always_comb begin
        state_d      = state_q;
        path_d       = path_q;
        phase_d      = phase_q;
        wb_valid     = 1'b0;
        instr_retire = 1'b0;
        trap_taken   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_done) begin
                    if (trap_valid) begin
                        trap_taken = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                        phase_d = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    if (trap_valid) begin
                        state_d    = S_FETCH;
                        trap_taken = 1'b1;
                    end else if (wfi) begin
                        state_d      = S_WFI;
                        instr_retire = 1'b1;
                    end else if (ctrl_path == CTRL_EXEC) begin
                        state_d      = S_FETCH;
                        wb_valid     = 1'b1;
                        instr_retire = 1'b1;
                    end else begin
                        state_d = S_MEM;
                        path_d  = ctrl_path;
                    end
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    if (trap_valid) begin
                        state_d    = S_FETCH;
                        trap_taken = 1'b1;
                    end else if (path_q == CTRL_AMO && !phase_q) begin
                        // AMO read data lands in rd before the second EXEC pass.
                        state_d  = S_EXEC;
                        phase_d  = 1'b1;
                        wb_valid = 1'b1;
                    end else begin
                        state_d      = S_FETCH;
                        instr_retire = 1'b1;
                        wb_valid     = (path_q != CTRL_AMO);
                    end
                end
            end
            S_WFI: begin
                if (irq_pending) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_stage_ctrl.sv
// Directed self-checking bench for core_stage_ctrl; inputs change on the
// falling edge and outputs are sampled 1ns later, away from the rising edge.
module tb_core_stage_ctrl;
    import core_pkg::*;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          fetch_stage_valid;
    logic          fetch_stage_ready;
    logic          exec_stage_valid;
    logic          exec_stage_ready;
    logic          exec_phase;
    ctrl_path_e    ctrl_path;
    logic          mem_stage_valid;
    logic          mem_stage_ready;
    logic          wfi;
    logic          irq_pending;
    logic          trap_valid;
    logic          wb_valid;
    logic          instr_retire;
    logic          trap_taken;
    logic [CW-1:0] retire_count;

    int            checks;
    int            errors;
    logic [CW-1:0] exp_count;

    core_stage_ctrl #(.RETIRE_CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_stage_valid (fetch_stage_valid),
        .fetch_stage_ready (fetch_stage_ready),
        .exec_stage_valid  (exec_stage_valid),
        .exec_stage_ready  (exec_stage_ready),
        .exec_phase        (exec_phase),
        .ctrl_path         (ctrl_path),
        .mem_stage_valid   (mem_stage_valid),
        .mem_stage_ready   (mem_stage_ready),
        .wfi               (wfi),
        .irq_pending       (irq_pending),
        .trap_valid        (trap_valid),
        .wb_valid          (wb_valid),
        .instr_retire      (instr_retire),
        .trap_taken        (trap_taken),
        .retire_count      (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] outs();
        return {fetch_stage_valid, exec_stage_valid, exec_phase, mem_stage_valid,
                wb_valid, instr_retire, trap_taken};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_stage_ready = 0; exec_stage_ready = 0; mem_stage_ready = 0;
        ctrl_path = CTRL_EXEC; wfi = 0; irq_pending = 0; trap_valid = 0;
        exp_count = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (outs() !== 7'b0) begin
            errors++; $display("[TB] FAIL reset_outs: actual=%b required=0000000", outs());
        end
        checks++;
        if (retire_count !== 4'd0) begin
            errors++; $display("[TB] FAIL reset_count: actual=%0d required=0", retire_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (outs() !== 7'b0) begin
            errors++; $display("[TB] FAIL idle_outs: actual=%b required=0000000", outs());
        end
    endtask

    // Starts in S_IDLE just after reset release; ends in S_FETCH with fetch_ready low.
    task automatic test_exec_path();
        fetch_stage_ready = 1; exec_stage_ready = 1; ctrl_path = CTRL_EXEC;
        @(negedge clk); #1;
        checks++;
        if (outs() !== 7'b1000000) begin
            errors++; $display("[TB] FAIL exec_c1: actual=%b required=1000000", outs());
        end
        @(negedge clk); #1;
        checks++;
        if (outs() !== 7'b0100110) begin
            errors++; $display("[TB] FAIL exec_c2: actual=%b required=0100110", outs());
        end
        exp_count++;
        @(negedge clk);
        fetch_stage_ready = 0;
        #1;
        checks++;
        if (retire_count !== exp_count || !fetch_stage_valid) begin
            errors++; $display("[TB] FAIL exec_c3: actual cnt=%0d fv=%b required cnt=%0d fv=1",
                               retire_count, fetch_stage_valid, exp_count);
        end
    endtask

    task automatic test_mem_path();
        fetch_stage_ready = 1; exec_stage_ready = 1; mem_stage_ready = 0; ctrl_path = CTRL_MEM;
        @(negedge clk);
        fetch_stage_ready = 0;
        #1;
        checks++;
        if (outs() !== 7'b0100000) begin
            errors++; $display("[TB] FAIL mem_exec: actual=%b required=0100000", outs());
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (outs() !== 7'b0001000) begin
                errors++; $display("[TB] FAIL mem_wait%0d: actual=%b required=0001000", i, outs());
            end
        end
        @(negedge clk);
        mem_stage_ready = 1;
        #1;
        checks++;
        if (outs() !== 7'b0001110) begin
            errors++; $display("[TB] FAIL mem_done: actual=%b required=0001110", outs());
        end
        exp_count++;
        @(negedge clk);
        mem_stage_ready = 0;
        #1;
        checks++;
        if (retire_count !== exp_count || outs() !== 7'b1000000) begin
            errors++; $display("[TB] FAIL mem_after: actual cnt=%0d outs=%b required cnt=%0d outs=1000000",
                               retire_count, outs(), exp_count);
        end
    endtask

    task automatic test_amo();
        fetch_stage_ready = 1; exec_stage_ready = 1; mem_stage_ready = 1; ctrl_path = CTRL_AMO;
        @(negedge clk);
        fetch_stage_ready = 0;
        #1;
        checks++;
        if (outs() !== 7'b0100000) begin
            errors++; $display("[TB] FAIL amo_e0: actual=%b required=0100000", outs());
        end
        @(negedge clk); #1;
        checks++;
        if (outs() !== 7'b0001100) begin
            errors++; $display("[TB] FAIL amo_m0: actual=%b required=0001100", outs());
        end
        @(negedge clk); #1;
        checks++;
        if (outs() !== 7'b0110000) begin
            errors++; $display("[TB] FAIL amo_e1: actual=%b required=0110000", outs());
        end
        @(negedge clk); #1;
        checks++;
        if (outs() !== 7'b0011010) begin
            errors++; $display("[TB] FAIL amo_m1: actual=%b required=0011010", outs());
        end
        exp_count++;
        @(negedge clk);
        mem_stage_ready = 0;
        #1;
        checks++;
        if (retire_count !== exp_count || outs() !== 7'b1010000) begin
            errors++; $display("[TB] FAIL amo_after: actual cnt=%0d outs=%b required cnt=%0d outs=1010000",
                               retire_count, outs(), exp_count);
        end
    endtask

    task automatic test_trap_exec();
        fetch_stage_ready = 1; exec_stage_ready = 1; ctrl_path = CTRL_MEM;
        @(negedge clk);
        fetch_stage_ready = 0; trap_valid = 1;
        #1;
        checks++;
        if (outs() !== 7'b0100001) begin
            errors++; $display("[TB] FAIL trap_exec: actual=%b required=0100001", outs());
        end
        @(negedge clk);
        trap_valid = 0;
        #1;
        checks++;
        if (outs() !== 7'b1000000 || retire_count !== exp_count) begin
            errors++; $display("[TB] FAIL trap_exec_after: actual outs=%b cnt=%0d required outs=1000000 cnt=%0d",
                               outs(), retire_count, exp_count);
        end
    endtask

    task automatic test_trap_fetch();
        fetch_stage_ready = 1; trap_valid = 1;
        #1;
        checks++;
        if (outs() !== 7'b1000001) begin
            errors++; $display("[TB] FAIL trap_fetch: actual=%b required=1000001", outs());
        end
        @(negedge clk);
        fetch_stage_ready = 0; trap_valid = 0;
        #1;
        checks++;
        if (outs() !== 7'b1000000) begin
            errors++; $display("[TB] FAIL trap_fetch_after: actual=%b required=1000000", outs());
        end
    endtask

    task automatic test_wfi();
        fetch_stage_ready = 1; exec_stage_ready = 1; ctrl_path = CTRL_EXEC; wfi = 1;
        @(negedge clk);
        fetch_stage_ready = 0;
        #1;
        checks++;
        if (outs() !== 7'b0100010) begin
            errors++; $display("[TB] FAIL wfi_exec: actual=%b required=0100010", outs());
        end
        exp_count++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wfi = 0;
            #1;
            checks++;
            if ({fetch_stage_valid, exec_stage_valid, mem_stage_valid} !== 3'b000) begin
                errors++; $display("[TB] FAIL wfi_park%0d: actual=%b required=000", i,
                                   {fetch_stage_valid, exec_stage_valid, mem_stage_valid});
            end
        end
        @(negedge clk);
        irq_pending = 1;
        #1;
        checks++;
        if ({fetch_stage_valid, exec_stage_valid, mem_stage_valid} !== 3'b000) begin
            errors++; $display("[TB] FAIL wfi_irq: actual=%b required=000",
                               {fetch_stage_valid, exec_stage_valid, mem_stage_valid});
        end
        @(negedge clk);
        irq_pending = 0;
        #1;
        checks++;
        if (!fetch_stage_valid || retire_count !== exp_count) begin
            errors++; $display("[TB] FAIL wfi_wake: actual fv=%b cnt=%0d required fv=1 cnt=%0d",
                               fetch_stage_valid, retire_count, exp_count);
        end
    endtask

    task automatic test_wfi_irq_early();
        fetch_stage_ready = 1; exec_stage_ready = 1; ctrl_path = CTRL_EXEC; wfi = 1;
        @(negedge clk);
        fetch_stage_ready = 0; irq_pending = 1;
        exp_count++;
        @(negedge clk);
        wfi = 0;
        #1;
        checks++;
        if (outs() !== 7'b0000000) begin
            errors++; $display("[TB] FAIL wfi_early_park: actual=%b required=0000000", outs());
        end
        @(negedge clk);
        irq_pending = 0;
        #1;
        checks++;
        if (!fetch_stage_valid || retire_count !== exp_count) begin
            errors++; $display("[TB] FAIL wfi_early_wake: actual fv=%b cnt=%0d required fv=1 cnt=%0d",
                               fetch_stage_valid, retire_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        fetch_stage_ready = 1; exec_stage_ready = 1; ctrl_path = CTRL_EXEC;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            @(negedge clk); #1;
            exp_count++;
            checks++;
            if (retire_count !== exp_count) begin
                errors++; $display("[TB] FAIL b2b_count%0d: actual=%0d required=%0d", i, retire_count, exp_count);
            end
        end
        fetch_stage_ready = 0;
    endtask

    task automatic test_reset_mid();
        fetch_stage_ready = 1; exec_stage_ready = 1; mem_stage_ready = 0; ctrl_path = CTRL_MEM;
        @(negedge clk);
        fetch_stage_ready = 0;
        @(negedge clk); #1;
        checks++;
        if (!mem_stage_valid) begin
            errors++; $display("[TB] FAIL rst_mid_mem: actual=%b required=1", mem_stage_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 7'b0 || retire_count !== 4'd0) begin
            errors++; $display("[TB] FAIL rst_mid_async: actual outs=%b cnt=%0d required outs=0000000 cnt=0",
                               outs(), retire_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
        #1;
        checks++;
        if (outs() !== 7'b0) begin
            errors++; $display("[TB] FAIL rst_mid_idle: actual=%b required=0000000", outs());
        end
        @(negedge clk); #1;
        checks++;
        if (outs() !== 7'b1000000) begin
            errors++; $display("[TB] FAIL rst_mid_restart: actual=%b required=1000000", outs());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exec_path();
        test_mem_path();
        test_amo();
        test_trap_exec();
        test_trap_fetch();
        test_wfi();
        test_wfi_irq_early();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_stage_ctrl.md
Name: core_stage_ctrl

Overview:
- Multi-cycle instruction sequencer for the single-issue core.
- Drives valid strobes to the FETCH, EXEC and MEM stages and sequences EXEC phases for two-phase instructions (AMO).
- Aborts the sequence on traps, parks the core on WFI, and emits write-back and retire pulses.
- Sits between the stage blocks and the trap handler; consumes the EXEC stage's registered-path decision (ctrl_path).

Parameters:
- RETIRE_CNT_W, 32, width of the internal retired-instruction counter (minstret source).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- fetch_stage_valid  out  1  FETCH stage may run
- fetch_stage_ready  in  1  FETCH done (instr/pc valid this cycle)
- exec_stage_valid  out  1  EXEC stage may run
- exec_stage_ready  in  1  EXEC done
- exec_phase  out  1  0 = first EXEC pass, 1 = second pass (AMO)
- ctrl_path  in  core_pkg::ctrl_path_e  path chosen by EXEC, sampled at EXEC done
- mem_stage_valid  out  1  MEM stage may run
- mem_stage_ready  in  1  MEM done
- wfi  in  1  current instr is WFI, sampled at EXEC done
- irq_pending  in  1  enabled interrupt pending (level)
- trap_valid  in  1  exception/interrupt raised; qualified by the stage done in the same cycle
- wb_valid  out  1  register-file write strobe (one cycle)
- instr_retire  out  1  one-cycle pulse per retired instruction
- trap_taken  out  1  one-cycle pulse when the sequence is aborted by a trap
- retire_count  out  RETIRE_CNT_W  free-running retired-instruction count

Behaviour:
Reset and outputs
- Async reset to S_IDLE with exec_phase = 0, path_q = CTRL_EXEC, retire_count = 0.
- While in reset, all outputs are 0.
- S_IDLE moves unconditionally to S_FETCH on the first clock after rst_n deasserts.
- Stage valids are pure state decodes: fetch_stage_valid = (S_FETCH), exec_stage_valid = (S_EXEC), mem_stage_valid = (S_MEM).
- A stage "done" means valid & ready in the same cycle. Valid stays high until done; there is no timeout.

ctrl_path_e (core_pkg)
- CTRL_EXEC: retire at EXEC.
- CTRL_MEM: EXEC -> MEM -> retire.
- CTRL_AMO: EXEC(phase 0) -> MEM(read) -> EXEC(phase 1) -> MEM(write) -> retire.

Transitions (all registered; one state per cycle minimum)
- S_FETCH, fetch done:
  - trap_valid -> S_FETCH (refetch from trap vector), trap_taken = 1.
  - else -> S_EXEC, exec_phase <= 0.
- S_EXEC, exec done:
  - trap_valid -> S_FETCH, trap_taken = 1, no wb/retire.
  - else if wfi -> S_WFI; wb_valid = 0, instr_retire = 1.
  - else if ctrl_path == CTRL_EXEC -> S_FETCH; wb_valid = 1, instr_retire = 1.
  - else -> S_MEM; path_q <= ctrl_path.
- S_MEM, mem done:
  - trap_valid -> S_FETCH, trap_taken = 1.
  - else if path_q == CTRL_AMO and exec_phase == 0 -> S_EXEC, exec_phase <= 1, wb_valid = 1 (loaded value to rd).
  - else -> S_FETCH; instr_retire = 1; wb_valid = 1 unless (path_q == CTRL_AMO) (store phase, rd already written).
- S_WFI: irq_pending -> S_FETCH (interrupt then reported by trap_valid at the next fetch done). irq_pending already high on entry leaves after exactly one cycle in S_WFI.

Outputs and counter
- wb_valid, instr_retire and trap_taken are combinational from state & done & inputs; never asserted together with trap_taken.
- retire_count increments on instr_retire and wraps at 2^RETIRE_CNT_W - 1 -> 0.
- exec_phase holds its value outside S_EXEC and is reset to 0 on every entry from S_FETCH.
- A trap during the AMO phase-1 EXEC or MEM write still aborts; the phase-0 wb is not undone.
- Reset asserted mid-sequence returns to S_IDLE immediately; no pulses are issued.

Decomposition:
- core_pkg: ctrl_path_e (CTRL_EXEC, CTRL_MEM, CTRL_AMO), ctrl_state_e (S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WFI).
- Single module; the retire counter stays inline (no sub-module).

Test Plan:
- Reset release, fetch/exec ready = 1, ctrl_path = CTRL_EXEC -> fetch_valid cycle 1, exec_valid cycle 2; wb_valid and instr_retire pulse at cycle 2; retire_count = 1 at cycle 3.
- CTRL_MEM with mem_stage_ready held low 5 cycles -> mem_stage_valid high for 6 cycles; single wb_valid/instr_retire on the 6th; retire_count += 1.
- CTRL_AMO, all ready = 1 -> valid sequence F, E(phase 0), M, E(phase 1), M; wb_valid at the first MEM done only; exactly one instr_retire.
- trap_valid at EXEC done of a CTRL_MEM instr -> trap_taken = 1, mem_stage_valid never asserted, next cycle fetch_stage_valid = 1, retire_count unchanged.
- wfi = 1 at EXEC done, irq_pending low 10 cycles then high -> all valids 0 for 10 cycles, fetch_stage_valid the cycle after irq_pending rises; retire_count += 1.
- retire_count preset to all-ones via retires (RETIRE_CNT_W = 4, 16 CTRL_EXEC instrs) -> wraps to 0; rst_n pulsed low during S_MEM -> all outputs 0 asynchronously, restart in S_IDLE.
